dsp_systolic_dot_acc: RTL

//  Downstream companion of the 18x18 systolic dot-product chain. Tags each NUM-wide chunk fed to the chain,
//  re-aligns the tags with the chain's fixed-latency result, and accumulates chunk results into one long dot product.

---
 rtl/dsp_systolic_pkg.sv | 42 ++++
 rtl/dsp_sync_fifo.sv | 62 ++++++
 rtl/dsp_systolic_dot_acc.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dsp_systolic_pkg.sv
// Shared types and helpers for the systolic dot-product accumulator.
// Holds the chunk tag, the completed-sum record and the saturating adder.
package dsp_systolic_pkg;

    localparam int DEF_RESULT_A_WIDTH = 44;
    localparam int DEF_ACC_WIDTH      = 48;
    localparam int DEF_CNT_WIDTH      = 16;
    localparam int MAX_W              = 64;

    typedef struct packed {
        logic v;
        logic last;
    } tag_t;

    typedef struct packed {
        logic signed [DEF_ACC_WIDTH-1:0] sum;
        logic [DEF_CNT_WIDTH-1:0]        count;
        logic                            sat;
    } res_t;

    typedef struct packed {
        logic signed [MAX_W-1:0] sum;
        logic                    ovf;
    } sat_out_t;

    // Operands must already fit in 'width' signed bits, so MAX_W never overflows.
    function automatic sat_out_t sat_add(input logic signed [MAX_W-1:0] a,
                                         input logic signed [MAX_W-1:0] b,
                                         input int unsigned             width);
        logic signed [MAX_W-1:0] s;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        sat_out_t                r;
        s     = a + b;
        hi    = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo    = -hi - 64'sd1;
        r.ovf = (s > hi) || (s < lo);
        r.sum = (s > hi) ? hi : ((s < lo) ? lo : s);
        return r;
    endfunction

endpackage

// File: rtl/dsp_sync_fifo.sv
// Generic show-ahead synchronous FIFO; the head word is visible while valid.
// Writes land one cycle after push; push and pop may coincide, even when full.
module dsp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full     = (count == CW'(DEPTH));
    assign valid    = (count != '0);
    assign do_pop   = pop && valid;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        (push && full) |-> do_pop);

endmodule

// File: rtl/dsp_systolic_dot_acc.sv
// Tags chunks entering the fixed-latency dot-product chain, re-aligns them with
// the chain result, accumulates long dot products and queues completed sums.
module dsp_systolic_dot_acc
    import dsp_systolic_pkg::*;
#(
    parameter int NUM            = 8,
    parameter int RESULT_A_WIDTH = DEF_RESULT_A_WIDTH,
    parameter int DSP_LATENCY    = 6,
    parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
    parameter int FIFO_DEPTH     = 4,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic                             in_last,
    output logic                             in_ready,
    input  logic signed [RESULT_A_WIDTH-1:0] dsp_result,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [ACC_WIDTH-1:0]      out_data,
    output logic [CNT_WIDTH-1:0]             out_count,
    output logic                             out_sat
);
    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
    localparam int RES_W  = ACC_WIDTH + CNT_WIDTH + 1;

    typedef struct packed {
        logic signed [ACC_WIDTH-1:0] sum;
        logic [CNT_WIDTH-1:0]        count;
        logic                        sat;
    } acc_res_t;

    if (ACC_WIDTH < RESULT_A_WIDTH) begin : g_acc_too_narrow
        $fatal(1, "ACC_WIDTH must be >= RESULT_A_WIDTH");
    end
    if (ACC_WIDTH >= MAX_W) begin : g_acc_too_wide
        $fatal(1, "ACC_WIDTH must be < 64");
    end
    if (DSP_LATENCY < 1) begin : g_bad_latency
        $fatal(1, "DSP_LATENCY must be >= 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "FIFO_DEPTH must be a power of two >= 2");
    end
    if (NUM < 1) begin : g_bad_num
        $fatal(1, "NUM must be >= 1");
    end

    tag_t                        tag_pipe [DSP_LATENCY];
    tag_t                        tail;
    logic                        accept;
    logic                        pop;
    logic                        push;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] base;
    logic                        first;
    logic                        sat_flag;
    logic [CNT_WIDTH-1:0]        cnt;
    logic [CNT_WIDTH-1:0]        cnt_inc;
    sat_out_t                    add;
    acc_res_t                    push_data;
    acc_res_t                    head;
    logic [CRED_W-1:0]           credits;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;
    assign tail   = tag_pipe[DSP_LATENCY-1];

    // The chain cannot stall, so the tag pipe shifts every cycle regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DSP_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= tag_t'{v: accept, last: accept && in_last};
            for (int i = 1; i < DSP_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_comb begin
        base           = first ? '0 : acc;
        add            = sat_add(MAX_W'(base), MAX_W'(dsp_result), ACC_WIDTH);
        cnt_inc        = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
        push           = tail.v && tail.last;
        push_data.sum  = add.sum[ACC_WIDTH-1:0];
        push_data.count = cnt_inc;
        push_data.sat  = sat_flag | add.ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            first    <= 1'b1;
            cnt      <= '0;
            sat_flag <= 1'b0;
        end else if (tail.v) begin
            if (tail.last) begin
                acc      <= '0;
                first    <= 1'b1;
                cnt      <= '0;
                sat_flag <= 1'b0;
            end else begin
                acc      <= push_data.sum;
                first    <= 1'b0;
                cnt      <= cnt_inc;
                sat_flag <= push_data.sat;
            end
        end
    end

    // A credit is taken when a last chunk is accepted and returned when its sum leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= '0;
        end else begin
            case ({accept && in_last, pop})
                2'b10:   credits <= credits + CRED_W'(1);
                2'b01:   credits <= credits - CRED_W'(1);
                default: credits <= credits;
            endcase
        end
    end

    assign in_ready = (credits < CRED_W'(FIFO_DEPTH));

    dsp_sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .valid     (out_valid),
        .count     (fifo_count)
    );

    assign out_data  = head.sum;
    assign out_count = head.count;
    assign out_sat   = head.sat;

    a_credits_cover_fifo: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= credits);
    a_sum_fits_acc: assert property (@(posedge clk) disable iff (!rst_n)
        add.sum == MAX_W'(push_data.sum));

endmodule
